multiword_adder_seq: RTL
========================

# multiword_adder_seq

Multi-cycle wide-operand adder that sequences an N_BITS-wide `ripple_adder` across WORDS chunks, least-significant chunk first, with the carry registered between cycles. It sits directly upstream of the `ripple_adder` and feeds it one chunk per cycle. It also consumes the adder's `sum`/`cout` and assembles them into a full-width result. This trades latency for area: wide additions reuse one narrow adder instead of a wide ripple chain. Operands enter and results leave on valid/ready handshakes.

## Interface
- N_BITS, 4, chunk width and width of the instantiated ripple_adder; must be ≥2.
- WORDS, 4, number of chunks; total width W = N_BITS*WORDS; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into chunk 0.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  W  registered result.
- cout  out  1  registered carry out of the top chunk.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into operand registers, load the carry register from cin, set idx=0, and go to BUSY.
- BUSY, one chunk per cycle:
  - The adder receives a_reg[idx*N_BITS +: N_BITS], b_reg[idx*N_BITS +: N_BITS] and the carry register.
  - At the edge: the adder sum goes to sum_reg chunk idx, the adder cout goes to the carry register, and idx increments.
  - When idx==WORDS-1 at the edge: the adder cout goes to the cout register and the state goes to DONE.
- DONE:
  - out_valid=1.
  - sum and cout are held stable.
  - in_valid is ignored (in_ready=0).
  - On out_valid&&out_ready: go to IDLE.
- sum and cout keep their last values after returning to IDLE. They are only meaningful while out_valid=1.
- Arithmetic: {cout,sum} = a + b + cin, exact modulo 2^(W+1). There is no signed interpretation and no overflow flag.
- idx width = max(1, $clog2(WORDS)). The idx comparison must not wrap for WORDS=1.

## Timing
- Reset values: state=IDLE, in_ready=1 (from the first edge with rst high), out_valid=0, sum=0, cout=0, carry=0, idx=0.
- rst has priority over every handshake. During any cycle in which rst is high:
  - in_valid and out_ready are ignored.
  - in_ready=1 and out_valid=0 from the following cycle.
- Reset mid-BUSY or mid-DONE aborts the operation with no output. The partially written sum is cleared to 0.
- Latency: if operands are accepted at edge E0, out_valid rises after edge E_WORDS, i.e. WORDS cycles after acceptance.
- Throughput: if out_ready is held high, the result handshake occurs at E_WORDS+1 and the next accept can occur no earlier than E_WORDS+2. Minimum issue interval is WORDS+2 cycles.
- in_ready and out_valid are decoded directly from registered state. They have no combinational path from in_valid or out_ready.
- in_valid may be held high across BUSY and DONE without effect. A new bundle is taken only in IDLE.
- Back-pressure: out_ready low holds DONE indefinitely. sum and cout must not change while held.

## Structure
- Shared package `multiword_adder_pkg`: state enum typedef (IDLE, BUSY, DONE).
- Sub-module: one instance of the existing `ripple_adder #(N_BITS)`. Its ports are a, b, cin, cout and sum.
- The top level contains only the FSM, idx counter, operand/carry/result registers and chunk muxing.
- No additional sub-modules.

## Test plan
All cases use N_BITS=4, WORDS=4 (W=16) unless stated otherwise.
- Carry across chunks: a=16'h00FF, b=16'h0001, cin=0 → sum=16'h0100, cout=0, out_valid exactly 4 cycles after accept.
- Full carry propagation: a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1.
- Back-pressure: a=16'h1234, b=16'h4321, cin=0 → sum=16'h5555.
  - Hold out_ready=0 for 3 cycles while toggling in_valid with new operands.
  - Required: sum stays stable, in_ready=0, no new operands captured.
- Reset mid-operation: assert rst for 1 cycle during the 2nd BUSY cycle.
  - Required: next cycle out_valid=0, sum=0, in_ready=1.
  - Following op a=16'h0001, b=16'h0001 gives sum=16'h0002.
- Back-to-back: in_valid and out_ready held high with two bundles (16'h8000+16'h8000, then 16'h0F0F+16'hF0F0).
  - Second accept is exactly 6 cycles after the first.
  - Results are {1,16'h0000} then {0,16'hFFFF}.
- Single chunk (N_BITS=8, WORDS=1): a=8'hF0, b=8'h10, cin=0 → sum=8'h00, cout=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared types for the sequenced multi-word adder.
package multiword_adder_pkg;

  // Controller states: waiting for operands, adding one chunk per cycle,
  // holding the finished result until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the chunk index. It is never narrower than one bit, so a
  // single-chunk build still gets a real counter and a non-wrapping compare.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_seq_ripple_adder.sv
// Narrow combinational ripple-carry adder reused once per chunk.
module ripple_adder #(
  parameter int N_BITS = 4
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              cin,
  output logic              cout,
  output logic [N_BITS-1:0] sum
);

  // Carry chain; w_carry[i] is the carry into bit i.
  logic [N_BITS:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[N_BITS];

endmodule

// File: rtl/multiword_adder_seq.sv
// Wide adder that streams W = N_BITS*WORDS operands through one narrow
// ripple_adder, least-significant chunk first, carrying between cycles.
module multiword_adder_seq
  import multiword_adder_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_BITS*WORDS-1:0]   a,
  input  logic [N_BITS*WORDS-1:0]   b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_BITS*WORDS-1:0]   sum,
  output logic                      cout
);

  localparam int W     = N_BITS * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;

  logic [31:0]        w_base;
  logic [N_BITS-1:0]  w_a_chunk;
  logic [N_BITS-1:0]  w_b_chunk;
  logic [N_BITS-1:0]  w_sum_chunk;
  logic               w_cout_chunk;
  logic               w_last;
  logic               w_accept;

  // Handshake flags come straight from the state register, so neither has
  // a combinational path from in_valid or out_ready.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_ready && in_valid;
  assign w_last    = (r_idx == IDX_LAST);

  // Select the current chunk of each captured operand.
  assign w_base    = 32'(r_idx) * 32'(N_BITS);
  assign w_a_chunk = r_a[w_base +: N_BITS];
  assign w_b_chunk = r_b[w_base +: N_BITS];

  ripple_adder #(
    .N_BITS (N_BITS)
  ) u_ripple_adder (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .cout (w_cout_chunk),
    .sum  (w_sum_chunk)
  );

  // State register; reset wins over every handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, walk chunks in BUSY, wait in DONE.
  always_comb begin
    // NOTE: default first so no path through the case leaves w_state_nxt
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture operands, then fold one chunk result per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, including the operand copies; an
    // aborted operation must leave a cleared sum, and the cost is trivial.
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        ST_BUSY: begin
          r_sum[w_base +: N_BITS] <= w_sum_chunk;
          r_carry                 <= w_cout_chunk;
          if (w_last) begin
            r_cout <= w_cout_chunk;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
